// File: rtl/mc6809_pkg.sv
// ---------------------------------------------------------------------------
// mc6809_pkg
// Shared definitions for the 6809 system-bus blocks.
//   arb_state_t          DMA arbiter FSM state (encoding is visible on the
//                        arbiter's debug 'state' port)
//   DMA_MAX_SAFE_CYCLES  longest DMA burst the core tolerates before its
//                        dynamic register contents are at risk
//   BURST_W/GAP_W/WAIT_W widths of the arbiter's burst, gap and wait counters
// ---------------------------------------------------------------------------
package mc6809_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam int DMA_MAX_SAFE_CYCLES = 14;

    localparam int BURST_W = 4;   // holds 0..14
    localparam int GAP_W   = 4;   // holds 0..15
    localparam int WAIT_W  = 8;   // holds 0..254

endpackage

// File: rtl/mc6809_dma_arbiter.sv
// ---------------------------------------------------------------------------
// mc6809_dma_arbiter
// Hands the 6809 system bus to a single external DMA master for a bounded
// burst of E cycles, then gives it back to the CPU and keeps the CPU on the
// bus for a minimum gap before the next request.
//
// Everything runs on the falling edge of CLK4 (the edge the E/Q enable
// generator uses) and the FSM only moves in cycles where CE_E_FALL is high.
// All outputs are registered and hold between strobes.
//
// Ports
//   CLK4        in   system clock, logic on negedge
//   nRESET      in   synchronous active-low reset
//   CE_E_FALL   in   one-CLK4 strobe at each E falling edge
//   CE_Q_FALL   in   one-CLK4 strobe at each Q falling edge (not used)
//   BA, BS      in   core bus-available / bus-status; both high = bus granted
//   dma_req     in   level request from the DMA master
//   nDMABREQ    out  DMA bus request to the core, active-low
//   dma_gnt     out  DMA master owns the bus
//   dma_cycle   out  one-CLK4 pulse per granted E cycle
//   burst_cnt   out  E cycles used in the current/last burst
//   timeout_err out  sticky grant-timeout flag, cleared only by reset
//   state       out  FSM state for debug
// ---------------------------------------------------------------------------
module mc6809_dma_arbiter
    import mc6809_pkg::*;
#(
    parameter int MAX_BURST     = DMA_MAX_SAFE_CYCLES,  // 1..14
    parameter int MIN_GAP       = 1,                    // 0..15
    parameter int GRANT_TIMEOUT = 16                    // 2..255
) (
    input  logic       CLK4,
    input  logic       nRESET,
    input  logic       CE_E_FALL,
    input  logic       CE_Q_FALL,
    input  logic       BA,
    input  logic       BS,
    input  logic       dma_req,
    output logic       nDMABREQ,
    output logic       dma_gnt,
    output logic       dma_cycle,
    output logic [3:0] burst_cnt,
    output logic       timeout_err,
    output logic [1:0] state
);

    arb_state_t          r_state;
    logic                r_nbreq;
    logic                r_gnt;
    logic                r_cycle;
    logic [BURST_W-1:0]  r_burst;
    logic [GAP_W-1:0]    r_gap;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_terr;

    arb_state_t          w_state_nxt;
    logic                w_nbreq_nxt;
    logic                w_gnt_nxt;
    logic                w_cycle_nxt;
    logic [BURST_W-1:0]  w_burst_nxt;
    logic [GAP_W-1:0]    w_gap_nxt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                w_terr_nxt;

    logic                w_bus_granted;
    logic [BURST_W-1:0]  w_burst_inc;
    logic                w_unused_q;

    // The Q strobe is part of the clock-enable bundle but the FSM only
    // needs E timing.
    assign w_unused_q = CE_Q_FALL;

    assign w_bus_granted = BA & BS;

    // Burst count after this strobe: only an E cycle actually used by the
    // master counts toward the burst limit.
    assign w_burst_inc = r_burst + (dma_req ? BURST_W'(1) : BURST_W'(0));

    always_comb begin
        w_state_nxt = r_state;
        w_nbreq_nxt = r_nbreq;
        w_gnt_nxt   = r_gnt;
        w_cycle_nxt = 1'b0;       // pulse: high only for the CLK4 after a strobe
        w_burst_nxt = r_burst;
        w_gap_nxt   = r_gap;
        w_wait_nxt  = r_wait;
        w_terr_nxt  = r_terr;

        if (CE_E_FALL) begin
            unique case (r_state)
                ST_IDLE: begin
                    w_nbreq_nxt = 1'b1;
                    w_gnt_nxt   = 1'b0;
                    if (r_gap != '0) begin
                        w_gap_nxt = r_gap - GAP_W'(1);
                    end else if (dma_req) begin
                        w_state_nxt = ST_REQ;
                        w_nbreq_nxt = 1'b0;
                        w_wait_nxt  = '0;
                    end
                end

                // Priority: grant, then request withdrawn, then timeout.
                ST_REQ: begin
                    if (w_bus_granted) begin
                        w_state_nxt = ST_GRANT;
                        w_gnt_nxt   = 1'b1;
                        w_burst_nxt = '0;
                    end else if (!dma_req) begin
                        w_state_nxt = ST_RELEASE;
                        w_nbreq_nxt = 1'b1;
                    end else if (r_wait == WAIT_W'(GRANT_TIMEOUT - 1)) begin
                        w_state_nxt = ST_RELEASE;
                        w_nbreq_nxt = 1'b1;
                        w_terr_nxt  = 1'b1;
                    end else begin
                        w_wait_nxt = r_wait + WAIT_W'(1);
                    end
                end

                // A request drop and the burst limit in the same strobe fall
                // into the same single release branch.
                ST_GRANT: begin
                    if (dma_req) begin
                        w_cycle_nxt = 1'b1;
                        w_burst_nxt = w_burst_inc;
                    end
                    if (!dma_req || (w_burst_inc == BURST_W'(MAX_BURST))) begin
                        w_state_nxt = ST_RELEASE;
                        w_gnt_nxt   = 1'b0;
                        w_nbreq_nxt = 1'b1;
                    end
                end

                // Wait for the core to take the bus back; no timeout here.
                ST_RELEASE: begin
                    if (!w_bus_granted) begin
                        w_state_nxt = ST_IDLE;
                        w_gap_nxt   = GAP_W'(MIN_GAP);
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Reset drops the bus request immediately, even mid-burst; the core
    // reclaims the bus on its own once nDMABREQ is high.
    always_ff @(negedge CLK4) begin
        if (!nRESET) begin
            r_state <= ST_IDLE;
            r_nbreq <= 1'b1;
            r_gnt   <= 1'b0;
            r_cycle <= 1'b0;
            r_burst <= '0;
            r_gap   <= '0;
            r_wait  <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_nbreq <= w_nbreq_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cycle <= w_cycle_nxt;
            r_burst <= w_burst_nxt;
            r_gap   <= w_gap_nxt;
            r_wait  <= w_wait_nxt;
            r_terr  <= w_terr_nxt;
        end
    end

    assign nDMABREQ    = r_nbreq;
    assign dma_gnt     = r_gnt;
    assign dma_cycle   = r_cycle;
    assign burst_cnt   = r_burst;
    assign timeout_err = r_terr;
    assign state       = r_state;

endmodule

// File: doc/mc6809_dma_arbiter.md
# mc6809_dma_arbiter

Sequences DMA access to the 6809 system bus. A single external DMA master requests the bus. The block drives the core's nDMABREQ, waits for the core's bus-grant indication (BA=1, BS=1), and grants the master a bounded burst of E cycles. It then returns the bus to the CPU and enforces a minimum CPU gap before the next request. It sits beside the CPU wrapper, runs on CLK4 and steps on the wrapper's E/Q clock-enable strobes.

## Interface
- MAX_BURST, 14, max granted E cycles per burst (1..14; 14 keeps core register refresh safe)
- MIN_GAP, 1, CPU-owned E cycles between release and next request (0..15)
- GRANT_TIMEOUT, 16, E cycles to wait for BA&BS before abort (2..255)
- CLK4  in  1  system clock; all logic on negedge CLK4, same edge as the clock-enable generator
- nRESET  in  1  synchronous, active-low reset, sampled on negedge CLK4
- CE_E_FALL  in  1  one-CLK4 strobe at each E falling edge
- CE_Q_FALL  in  1  one-CLK4 strobe at each Q falling edge (unused by FSM; reserved, tie allowed)
- BA  in  1  core bus-available
- BS  in  1  core bus-status
- dma_req  in  1  level request from DMA master
- nDMABREQ  out  1  to core, active-low
- dma_gnt  out  1  DMA master owns the bus
- dma_cycle  out  1  one-CLK4 pulse per granted E cycle; the master advances its address on it
- burst_cnt  out  4  E cycles used in the current burst
- timeout_err  out  1  sticky; set on grant timeout, cleared only by reset
- state  out  2  FSM state for debug

## Operation
- All FSM decisions are taken only in CLK4 cycles where CE_E_FALL=1. Outputs are registered and hold between strobes.
- States: IDLE=0, REQ=1, GRANT=2, RELEASE=3.
- IDLE:
  - nDMABREQ=1 and dma_gnt=0.
  - If gap_cnt≠0, decrement gap_cnt.
  - Otherwise, if dma_req=1: go to REQ, nDMABREQ←0, wait_cnt←0.
- REQ, evaluated in priority order:
  1. BA&BS=1: go to GRANT, dma_gnt←1, burst_cnt←0.
  2. dma_req=0: nDMABREQ←1, go to RELEASE.
  3. wait_cnt=GRANT_TIMEOUT−1: timeout_err←1, nDMABREQ←1, go to RELEASE.
  4. Otherwise wait_cnt++.
- GRANT, on each strobe:
  - If dma_req=1: dma_cycle pulses and burst_cnt++.
  - If dma_req=0, or if the incremented burst_cnt reaches MAX_BURST: dma_gnt←0, nDMABREQ←1, go to RELEASE. burst_cnt holds its final value.
- RELEASE: when BA&BS=0, go to IDLE and set gap_cnt←MIN_GAP. Otherwise wait; this state has no timeout.
- Simultaneous events:
  - Grant beats timeout and request drop.
  - A request drop and MAX_BURST in the same strobe cause a single release.
  - A dma_req pulse shorter than one E period may be missed. This is allowed.
- Reset values: nDMABREQ=1, dma_gnt=0, dma_cycle=0, burst_cnt=0, timeout_err=0, state=IDLE, gap_cnt=0, wait_cnt=0.
- Reset asserted mid-burst returns every output to its reset value on the next negedge. There is no release handshake in that case.

## Timing
- All outputs update on the negedge CLK4 where CE_E_FALL=1 was sampled, i.e. 1 CLK4 after the strobe. dma_cycle is high for exactly that one CLK4 cycle.
- Request latency: nDMABREQ falls at the first CE_E_FALL with dma_req=1 and gap_cnt=0.
- Grant latency: dma_gnt rises at the first CE_E_FALL where BA&BS=1 is sampled.
- A full burst gives MAX_BURST dma_cycle pulses, one per E period (4 CLK4).
- nDMABREQ deasserts on the same edge that dma_gnt falls.
- After BA&BS falls, the next nDMABREQ assertion comes no earlier than MIN_GAP+1 E strobes later.

## Structure
- Shared package mc6809_pkg holds:
  - the arbiter state enum (IDLE/REQ/GRANT/RELEASE);
  - constant DMA_MAX_SAFE_CYCLES=14;
  - widths for burst, gap and wait counters.
- No sub-module: three small counters and a 4-state FSM, all inline.

## Test plan
- Single short burst. MIN_GAP=1, dma_req held for 3 E cycles after grant, BA&BS returned 2 E after nDMABREQ falls. Required: nDMABREQ low for 5 E; exactly 3 dma_cycle pulses; burst_cnt=3; state back to IDLE after BA&BS drops.
- Max burst. dma_req held high continuously, MAX_BURST=14. Required: 14 dma_cycle pulses, then nDMABREQ=1. After BA&BS falls, a 1-E gap, then nDMABREQ re-asserts.
- Grant timeout. GRANT_TIMEOUT=16, BA&BS never assert. Required: nDMABREQ released after 16 E strobes, timeout_err=1 and sticky, state passes through RELEASE to IDLE.
- Request withdrawn before grant. dma_req drops at the 2nd E strobe in REQ. Required: nDMABREQ=1, no dma_gnt, no dma_cycle.
- Reset mid-burst. nRESET low during the 5th granted E cycle. Required: next negedge gives nDMABREQ=1, dma_gnt=0, burst_cnt=0, state=IDLE, timeout_err=0.
- Simultaneous events. dma_req drops on the same strobe burst_cnt reaches MAX_BURST. Separately, BA&BS rises on the timeout strobe. Required: the first causes a single release with no extra dma_cycle; the second grants with timeout_err=0.
